// File: rtl/btb_set_assoc_if.sv
// Bundle of BTB lookup, update and flush signals.
//   master : PC-gen / EX side. Drives lk_pc, upd_*, flush_req; receives lk_*, flush_busy.
//   slave  : the BTB itself.
interface btb_set_assoc_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] lk_pc;
  logic            lk_hit;
  logic [PC_W-1:0] lk_target;
  logic            lk_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;
  logic            flush_req;
  logic            flush_busy;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    input  lk_hit, lk_target, lk_taken, flush_busy
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    output lk_hit, lk_target, lk_taken, flush_busy
  );
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer.
//   clk, rst_n (async, active-low) : plain ports
//   bus (slave)  : lk_pc -> lk_hit/lk_target/lk_taken (combinational lookup)
//                  upd_valid/upd_pc/upd_target/upd_taken (EX resolve, applied at posedge)
//                  flush_req -> flush_busy (SETS-cycle invalidate sweep)
// Index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2]; 2-bit saturating direction counter per way.
module btb_set_assoc #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 2
) (
  input logic            clk,
  input logic            rst_n,
  btb_set_assoc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   fl_idx_q;
  logic               busy_q;

  logic               valid_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [PC_W-1:0]    tgt_q   [SETS][WAYS];
  logic [1:0]         ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0]   vptr_q  [SETS];

  // Low PC bits are instruction-alignment bits and never participate.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

  // ---------------- Lookup (combinational, pre-edge state) ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit_d;
  logic [PC_W-1:0]  lk_tgt_d;
  logic             lk_taken_d;

  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign lk_tag = bus.lk_pc[PC_W-1:IDX_W+2];

  always_comb begin
    lk_hit_d   = 1'b0;
    lk_tgt_d   = '0;
    lk_taken_d = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit_d   = 1'b1;
        lk_tgt_d   = tgt_q[lk_idx][w];
        lk_taken_d = ctr_q[lk_idx][w][1];
      end
    end
    // Entries mid-sweep are in a mixed state; suppress all hits until done.
    if (state_q != IDLE) begin
      lk_hit_d   = 1'b0;
      lk_tgt_d   = '0;
      lk_taken_d = 1'b0;
    end
  end

  assign bus.lk_hit     = lk_hit_d;
  assign bus.lk_target  = lk_tgt_d;
  assign bus.lk_taken   = lk_taken_d;
  assign bus.flush_busy = busy_q;

  // ---------------- Update way selection ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [WAY_W-1:0] u_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] alloc_way_d;
  logic [1:0]       u_ctr;
  logic [1:0]       ctr_inc_d;
  logic [1:0]       ctr_dec_d;

  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[PC_W-1:IDX_W+2];

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = w[WAY_W-1:0];
      end
      if (!inv_found && !valid_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = w[WAY_W-1:0];
      end
    end
    alloc_way_d = inv_found ? inv_way : vptr_q[u_idx];
    u_ctr       = ctr_q[u_idx][u_way];
    ctr_inc_d   = (u_ctr == 2'd3) ? 2'd3 : u_ctr + 2'd1;
    ctr_dec_d   = (u_ctr == 2'd0) ? 2'd0 : u_ctr - 2'd1;
  end

  // ---------------- State ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fl_idx_q <= '0;
      busy_q   <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          // A flush request wins over a same-cycle update, which is dropped.
          if (bus.flush_req) begin
            state_q  <= FLUSH;
            fl_idx_q <= '0;
            busy_q   <= 1'b1;
          end else if (bus.upd_valid) begin
            if (u_hit) begin
              if (bus.upd_taken) begin
                tgt_q[u_idx][u_way] <= bus.upd_target;
                ctr_q[u_idx][u_way] <= ctr_inc_d;
              end else begin
                ctr_q[u_idx][u_way] <= ctr_dec_d;
              end
            end else if (bus.upd_taken) begin
              valid_q[u_idx][alloc_way_d] <= 1'b1;
              tag_q[u_idx][alloc_way_d]   <= u_tag;
              tgt_q[u_idx][alloc_way_d]   <= bus.upd_target;
              ctr_q[u_idx][alloc_way_d]   <= 2'b10;
              // Round-robin only advances when a live entry was displaced.
              if ((WAYS > 1) && !inv_found) begin
                vptr_q[u_idx] <= vptr_q[u_idx] + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          vptr_q[fl_idx_q] <= '0;
          for (int unsigned w = 0; w < WAYS; w++) begin
            valid_q[fl_idx_q][w] <= 1'b0;
            ctr_q[fl_idx_q][w]   <= '0;
          end
          fl_idx_q <= fl_idx_q + 1'b1;
          if (fl_idx_q == IDX_W'(SETS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btb_set_assoc.sv
module tb_btb_set_assoc;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  btb_set_assoc_if #(.PC_W(32)) bus ();

  btb_set_assoc #(.PC_W(32), .SETS(16), .WAYS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic hit, input logic [31:0] tgt, input logic tkn);
    bus.lk_pc = pc;
    #1;
    check({tag, ".hit"},    32'(bus.lk_hit),   32'(hit));
    check({tag, ".target"}, bus.lk_target,     tgt);
    check({tag, ".taken"},  32'(bus.lk_taken), 32'(tkn));
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tkn;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.lk_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_target = '0; bus.upd_taken = 1'b0; bus.flush_req = 1'b0;
    repeat (2) tick();

    // T1: reset state
    check("t1.busy_in_reset", 32'(bus.flush_busy), 0);
    lookup("t1.rst_100", 32'h100, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
    lookup("t1.post_deadbeec", 32'hDEADBEEC, 1'b0, 32'h0, 1'b0);
    check("t1.busy", 32'(bus.flush_busy), 0);

    // T2: allocate then retrain counter, including saturation at both ends
    upd(32'h100, 32'h240, 1'b1);                          // ctr 2
    lookup("t2.alloc", 32'h100, 1'b1, 32'h240, 1'b1);
    upd(32'h100, 32'h0, 1'b0);                            // ctr 1
    upd(32'h100, 32'h0, 1'b0);                            // ctr 0
    lookup("t2.nt2", 32'h100, 1'b1, 32'h240, 1'b0);
    upd(32'h100, 32'h0, 1'b0);                            // ctr 0 (sat)
    upd(32'h100, 32'h280, 1'b1);                          // ctr 1, tgt 280
    lookup("t2.satlo", 32'h100, 1'b1, 32'h280, 1'b0);
    upd(32'h100, 32'h280, 1'b1);                          // ctr 2
    upd(32'h100, 32'h280, 1'b1);                          // ctr 3
    upd(32'h100, 32'h280, 1'b1);                          // ctr 3 (sat)
    upd(32'h100, 32'h0, 1'b0);                            // ctr 2
    lookup("t2.sathi", 32'h100, 1'b1, 32'h280, 1'b1);

    // T3: fresh start, eviction order within set 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    upd(32'h100, 32'hA100, 1'b1);                         // way0
    upd(32'h500, 32'hA500, 1'b1);                         // way1
    upd(32'h900, 32'hA900, 1'b1);                         // evict way0, ptr->1
    lookup("t3.100", 32'h100, 1'b0, 32'h0, 1'b0);
    lookup("t3.500", 32'h500, 1'b1, 32'hA500, 1'b1);
    lookup("t3.900", 32'h900, 1'b1, 32'hA900, 1'b1);
    upd(32'hD00, 32'hAD00, 1'b1);                         // evict way1, ptr->0
    lookup("t3.500b", 32'h500, 1'b0, 32'h0, 1'b0);
    lookup("t3.900b", 32'h900, 1'b1, 32'hA900, 1'b1);
    lookup("t3.D00", 32'hD00, 1'b1, 32'hAD00, 1'b1);
    lookup("t3.alias", 32'h10900, 1'b0, 32'h0, 1'b0);

    // T4: not-taken miss allocates nothing
    upd(32'h300, 32'hA300, 1'b0);
    lookup("t4.300", 32'h300, 1'b0, 32'h0, 1'b0);
    lookup("t4.900", 32'h900, 1'b1, 32'hA900, 1'b1);

    // T5: fill, flush sweep, dropped update, victim pointer reset
    upd(32'h1100, 32'hB100, 1'b1);                        // evicts 900 (way0), ptr->1
    upd(32'h104, 32'hC104, 1'b1);
    upd(32'h108, 32'hC108, 1'b1);
    upd(32'h10C, 32'hC10C, 1'b1);
    lookup("t5.pre104", 32'h104, 1'b1, 32'hC104, 1'b1);
    bus.flush_req = 1'b1;
    #1;
    check("t5.busy_at_req", 32'(bus.flush_busy), 0);
    tick();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus.flush_req = 1'b1;
      if (i == 15) begin
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h104;
        bus.upd_target = 32'hEEEE; bus.upd_taken = 1'b1;
      end
      check($sformatf("t5.busy%0d", i), 32'(bus.flush_busy), 1);
      if (i == 0) lookup("t5.during", 32'h104, 1'b0, 32'h0, 1'b0);
      tick();
      bus.flush_req = 1'b0;
      bus.upd_valid = 1'b0;
    end
    check("t5.busy_end", 32'(bus.flush_busy), 0);
    lookup("t5.104", 32'h104, 1'b0, 32'h0, 1'b0);
    lookup("t5.108", 32'h108, 1'b0, 32'h0, 1'b0);
    lookup("t5.1100", 32'h1100, 1'b0, 32'h0, 1'b0);
    lookup("t5.D00", 32'hD00, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 32'hF100, 1'b1);                         // way0
    upd(32'h500, 32'hF500, 1'b1);                         // way1
    upd(32'h900, 32'hF900, 1'b1);                         // ptr 0 -> evicts 100
    lookup("t5.new100", 32'h100, 1'b0, 32'h0, 1'b0);
    lookup("t5.new500", 32'h500, 1'b1, 32'hF500, 1'b1);
    lookup("t5.new900", 32'h900, 1'b1, 32'hF900, 1'b1);

    // T6: reset during flush
    upd(32'h13C, 32'hE13C, 1'b1);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("t6.busy1", 32'(bus.flush_busy), 1);
    repeat (4) tick();
    check("t6.busy5", 32'(bus.flush_busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6.busy_rst", 32'(bus.flush_busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup("t6.13C", 32'h13C, 1'b0, 32'h0, 1'b0);
    lookup("t6.500", 32'h500, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    check("t6.busy_after", 32'(bus.flush_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
